// File: rtl/ternary_popcount_neuron_seq_if.sv
// Handshake and popcount-unit bus for the sequential ternary neuron.
// slave = the neuron controller, master = its surroundings (feature source, popcount unit, next layer).
interface ternary_popcount_neuron_seq_if #(
  parameter int NUM_CHUNKS = 4,
  parameter int CHUNK_W    = 24,
  parameter int PC_W       = 5,
  parameter int ACC_W      = 7
);
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_CHUNKS*CHUNK_W-1:0]  in_x;
  logic [NUM_CHUNKS*CHUNK_W-1:0]  in_wpos;
  logic [NUM_CHUNKS*CHUNK_W-1:0]  in_wneg;
  logic signed [ACC_W:0]          in_thr_hi;
  logic signed [ACC_W:0]          in_thr_lo;
  logic [CHUNK_W-1:0]             pc_operand;
  logic [PC_W-1:0]                pc_result;
  logic                           out_valid;
  logic                           out_ready;
  logic [1:0]                     out_act;
  logic signed [ACC_W:0]          out_sum;

  modport slave (
    input  in_valid, in_x, in_wpos, in_wneg, in_thr_hi, in_thr_lo, pc_result, out_ready,
    output in_ready, pc_operand, out_valid, out_act, out_sum
  );

  modport master (
    output in_valid, in_x, in_wpos, in_wneg, in_thr_hi, in_thr_lo, pc_result, out_ready,
    input  in_ready, pc_operand, out_valid, out_act, out_sum
  );
endinterface

// File: rtl/ternary_popcount_neuron_seq.sv
// Ternary neuron sharing one external popcount unit: POS/NEG pass per chunk, result 2*NUM_CHUNKS+1 cycles after accept.
// Accepts only in IDLE; holds the result in DONE until out_ready, no overlap with the next input.
module ternary_popcount_neuron_seq #(
  parameter int NUM_CHUNKS = 4,
  parameter int CHUNK_W    = 24,
  parameter int PC_W       = 5,
  parameter int ACC_W      = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  ternary_popcount_neuron_seq_if.slave  bus
);
  localparam int VEC_W = NUM_CHUNKS * CHUNK_W;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, POS, NEG, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [VEC_W-1:0]      r_x;
  logic [VEC_W-1:0]      r_ep;
  logic [VEC_W-1:0]      r_en;
  logic signed [ACC_W:0] r_thr_hi;
  logic signed [ACC_W:0] r_thr_lo;
  logic [ACC_W-1:0]      r_pos_acc;
  logic [ACC_W-1:0]      r_neg_acc;
  logic                  r_out_valid;
  logic [1:0]            r_out_act;
  logic signed [ACC_W:0] r_out_sum;

  logic [CHUNK_W-1:0]    w_x_chunk;
  logic [CHUNK_W-1:0]    w_ep_chunk;
  logic [CHUNK_W-1:0]    w_en_chunk;
  logic                  w_last;
  logic [ACC_W-1:0]      w_acc_cur;
  logic [ACC_W:0]        w_acc_sum;
  logic [ACC_W-1:0]      w_acc_sat;
  logic signed [ACC_W:0] w_diff;
  logic [1:0]            w_act;

  always_comb begin
    w_x_chunk  = '0;
    w_ep_chunk = '0;
    w_en_chunk = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_x_chunk  = r_x[k*CHUNK_W +: CHUNK_W];
        w_ep_chunk = r_ep[k*CHUNK_W +: CHUNK_W];
        w_en_chunk = r_en[k*CHUNK_W +: CHUNK_W];
      end
    end
  end

  assign w_last = (r_idx == IDX_W'(NUM_CHUNKS - 1));

  // Saturate instead of wrapping: an approximate popcount unit may over-report.
  assign w_acc_cur = (r_state == NEG) ? r_neg_acc : r_pos_acc;
  assign w_acc_sum = {1'b0, w_acc_cur} + {{(ACC_W + 1 - PC_W){1'b0}}, bus.pc_result};
  assign w_acc_sat = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];

  // Used only on the NEG->DONE edge, so the last NEG addition is the saturated value.
  assign w_diff = $signed({1'b0, r_pos_acc}) - $signed({1'b0, w_acc_sat});

  always_comb begin
    w_act = 2'b00;
    if (w_diff >= r_thr_hi) begin
      w_act = 2'b01;
    end else if (w_diff <= r_thr_lo) begin
      w_act = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.in_ready   = 1'b0;
    bus.pc_operand = '0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = POS;
      end
      POS: begin
        bus.pc_operand = w_x_chunk & w_ep_chunk;
        w_state_nxt    = NEG;
      end
      NEG: begin
        bus.pc_operand = w_x_chunk & w_en_chunk;
        w_state_nxt    = w_last ? DONE : POS;
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_x         <= '0;
      r_ep        <= '0;
      r_en        <= '0;
      r_thr_hi    <= '0;
      r_thr_lo    <= '0;
      r_pos_acc   <= '0;
      r_neg_acc   <= '0;
      r_out_valid <= 1'b0;
      r_out_act   <= 2'b00;
      r_out_sum   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_x       <= bus.in_x;
            r_ep      <= bus.in_wpos & ~bus.in_wneg;
            r_en      <= bus.in_wneg & ~bus.in_wpos;
            r_thr_hi  <= bus.in_thr_hi;
            r_thr_lo  <= bus.in_thr_lo;
            r_pos_acc <= '0;
            r_neg_acc <= '0;
            r_idx     <= '0;
          end
        end
        POS: r_pos_acc <= w_acc_sat;
        NEG: begin
          r_neg_acc <= w_acc_sat;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_diff;
            r_out_act   <= w_act;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_act   = r_out_act;
  assign bus.out_sum   = r_out_sum;
endmodule

// File: tb/tb_ternary_popcount_neuron_seq.sv
// Bench for ternary_popcount_neuron_seq: exact and stuck-high popcount models, scoreboard of expected results.
module tb_ternary_popcount_neuron_seq;
  localparam int NC = 4;
  localparam int CW = 24;
  localparam int PW = 5;
  localparam int AW = 7;
  localparam int VW = NC * CW;

  typedef struct packed {
    logic [AW:0] sum;
    logic [1:0]  act;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  bit   stuck;
  int   checks;
  int   errors;
  exp_t sb[$];

  always #5 clk = ~clk;

  ternary_popcount_neuron_seq_if #(.NUM_CHUNKS(NC), .CHUNK_W(CW), .PC_W(PW), .ACC_W(AW)) bus ();
  ternary_popcount_neuron_seq_if #(.NUM_CHUNKS(NC), .CHUNK_W(CW), .PC_W(PW), .ACC_W(6))  bus6 ();

  ternary_popcount_neuron_seq #(.NUM_CHUNKS(NC), .CHUNK_W(CW), .PC_W(PW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  ternary_popcount_neuron_seq #(.NUM_CHUNKS(NC), .CHUNK_W(CW), .PC_W(PW), .ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6)
  );

  // Stuck model reports 31 for any non-zero operand.
  always_comb bus.pc_result = (stuck && bus.pc_operand != '0) ? PW'(31) : PW'($countones(bus.pc_operand));
  always_comb bus6.pc_result = (bus6.pc_operand != '0) ? PW'(31) : PW'(0);

  function automatic exp_t model(input logic [VW-1:0] x, input logic [VW-1:0] wp, input logic [VW-1:0] wn,
                                 input logic signed [AW:0] hi, input logic signed [AW:0] lo);
    int s;
    int h;
    int l;
    exp_t e;
    s = $countones(x & wp & ~wn) - $countones(x & wn & ~wp);
    h = hi;
    l = lo;
    e.sum = (AW + 1)'(s);
    if (s >= h) e.act = 2'b01;
    else if (s <= l) e.act = 2'b11;
    else e.act = 2'b00;
    return e;
  endfunction

  task automatic drive(input logic [VW-1:0] x, input logic [VW-1:0] wp, input logic [VW-1:0] wn,
                       input logic signed [AW:0] hi, input logic signed [AW:0] lo);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL drive_timeout in_ready=%0b required 1", bus.in_ready);
    end
    bus.in_x      = x;
    bus.in_wpos   = wp;
    bus.in_wneg   = wn;
    bus.in_thr_hi = hi;
    bus.in_thr_lo = lo;
    bus.in_valid  = 1'b1;
    sb.push_back(model(x, wp, wn, hi, lo));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 40);
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    checks++;
    if (bus.out_act !== 2'b00) begin errors++; $display("FAIL reset_out_act got %b want 00", bus.out_act); end
    checks++;
    if (bus.out_sum !== 8'h00) begin errors++; $display("FAIL reset_out_sum got %h want 00", bus.out_sum); end
    checks++;
    if (bus.pc_operand !== 24'h0) begin errors++; $display("FAIL reset_pc_operand got %h want 0", bus.pc_operand); end
  endtask

  task automatic test_all_pos();
    int   n;
    exp_t e;
    drive({VW{1'b1}}, {VW{1'b1}}, {VW{1'b0}}, 8'sd10, -8'sd10);
    wait_out(n);
    checks++;
    if (bus.out_valid !== 1'b1 || n != 9) begin
      errors++; $display("FAIL allpos_latency valid=%0b cycle=%0d want cycle 9", bus.out_valid, n);
    end
    e = sb.pop_front();
    checks++;
    if (bus.out_sum !== e.sum) begin errors++; $display("FAIL allpos_sum got %0d want %0d", bus.out_sum, e.sum); end
    checks++;
    if (bus.out_sum !== 8'd96) begin errors++; $display("FAIL allpos_sum96 got %0d want 96", bus.out_sum); end
    checks++;
    if (bus.out_act !== e.act) begin errors++; $display("FAIL allpos_act got %b want %b", bus.out_act, e.act); end
    release_out();
  endtask

  task automatic test_mixed();
    int          n;
    exp_t        e;
    logic [23:0] ops [8];
    logic [VW-1:0] wp;
    logic [VW-1:0] wn;
    ops = '{24'hFFFFFF, 24'h0, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'h0, 24'hFFFFFF};
    wp = {{(VW-CW){1'b0}}, {CW{1'b1}}};
    wn = {{(VW-CW){1'b1}}, {CW{1'b0}}};
    drive({VW{1'b1}}, wp, wn, 8'sd10, -8'sd5);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.pc_operand !== ops[k]) begin
        errors++; $display("FAIL mixed_operand cycle %0d got %h want %h", k + 1, bus.pc_operand, ops[k]);
      end
    end
    wait_out(n);
    checks++;
    if (bus.out_valid !== 1'b1 || n != 1) begin
      errors++; $display("FAIL mixed_latency valid=%0b extra=%0d want 1", bus.out_valid, n);
    end
    e = sb.pop_front();
    checks++;
    if (bus.out_sum !== e.sum || bus.out_sum !== 8'hD0) begin
      errors++; $display("FAIL mixed_sum got %h want %h", bus.out_sum, e.sum);
    end
    checks++;
    if (bus.out_act !== 2'b11) begin errors++; $display("FAIL mixed_act got %b want 11", bus.out_act); end
    release_out();
  endtask

  task automatic test_cancel();
    int   n;
    exp_t e;
    drive({VW{1'b1}}, {VW{1'b1}}, {VW{1'b1}}, 8'sd1, -8'sd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.pc_operand !== 24'h0) begin
        errors++; $display("FAIL cancel_operand cycle %0d got %h want 0", k + 1, bus.pc_operand);
      end
    end
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum) begin
      errors++; $display("FAIL cancel_sum valid=%0b got %0d want %0d", bus.out_valid, bus.out_sum, e.sum);
    end
    checks++;
    if (bus.out_act !== 2'b00) begin errors++; $display("FAIL cancel_act got %b want 00", bus.out_act); end
    release_out();
  endtask

  task automatic test_backpressure();
    int   n;
    exp_t e;
    logic [VW-1:0] xb;
    drive({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
          8'sd3, -8'sd3);
    wait_out(n);
    e = sb.pop_front();
    xb = {VW{1'b1}};
    bus.in_x      = xb;
    bus.in_wpos   = xb;
    bus.in_wneg   = '0;
    bus.in_thr_hi = 8'sd10;
    bus.in_thr_lo = -8'sd10;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_act !== e.act || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d valid=%0b sum=%0d act=%b rdy=%0b want 1/%0d/%b/0",
                 k, bus.out_valid, bus.out_sum, bus.out_act, bus.in_ready, e.sum, e.act);
      end
    end
    release_out();
    sb.push_back(model(xb, xb, '0, 8'sd10, -8'sd10));
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_return rdy=%0b valid=%0b want 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || n != 9 || bus.out_sum !== e.sum || bus.out_act !== e.act) begin
      errors++; $display("FAIL hold_next cycle=%0d sum=%0d act=%b want 9/%0d/%b", n, bus.out_sum, bus.out_act, e.sum, e.act);
    end
    release_out();
  endtask

  task automatic test_mid_reset();
    int   n;
    exp_t e;
    drive({$urandom, $urandom, $urandom}, {VW{1'b1}}, {VW{1'b0}}, 8'sd10, -8'sd10);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.pc_operand !== 24'h0) begin
      errors++; $display("FAIL midrst_state rdy=%0b valid=%0b op=%h want 1/0/0", bus.in_ready, bus.out_valid, bus.pc_operand);
    end
    checks++;
    if (dut.r_pos_acc !== 7'd0 || dut.r_neg_acc !== 7'd0) begin
      errors++; $display("FAIL midrst_acc pos=%0d neg=%0d want 0/0", dut.r_pos_acc, dut.r_neg_acc);
    end
    // Reset while a result is pending discards it.
    drive({VW{1'b1}}, {VW{1'b1}}, {VW{1'b0}}, 8'sd10, -8'sd10);
    wait_out(n);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 8'h00 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL donerst valid=%0b sum=%0d rdy=%0b want 0/0/1", bus.out_valid, bus.out_sum, bus.in_ready);
    end
    drive({VW{1'b1}}, {VW{1'b1}}, {VW{1'b0}}, 8'sd10, -8'sd10);
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_act !== e.act) begin
      errors++; $display("FAIL midrst_next sum=%0d act=%b want %0d/%b", bus.out_sum, bus.out_act, e.sum, e.act);
    end
    release_out();
  endtask

  task automatic test_saturation();
    int   n;
    exp_t e;
    stuck = 1'b1;
    drive({VW{1'b1}}, {VW{1'b1}}, {VW{1'b0}}, 8'sd10, -8'sd10);
    void'(sb.pop_back());
    sb.push_back('{sum: 8'd124, act: 2'b01});
    wait_out(n);
    e = sb.pop_front();
    checks++;
    if (dut.r_pos_acc !== 7'd124) begin errors++; $display("FAIL stuck_posacc got %0d want 124", dut.r_pos_acc); end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== e.sum || bus.out_act !== e.act) begin
      errors++; $display("FAIL stuck_out sum=%0d act=%b want %0d/%b", bus.out_sum, bus.out_act, e.sum, e.act);
    end
    release_out();
    stuck = 1'b0;

    n = 0;
    @(negedge clk);
    bus6.in_x      = {VW{1'b1}};
    bus6.in_wpos   = {VW{1'b1}};
    bus6.in_wneg   = '0;
    bus6.in_thr_hi = 7'sd10;
    bus6.in_thr_lo = -7'sd10;
    bus6.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus6.in_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus6.out_valid && n < 40);
    checks++;
    if (bus6.out_valid !== 1'b1 || dut6.r_pos_acc !== 6'd63) begin
      errors++; $display("FAIL narrow_sat valid=%0b posacc=%0d want 1/63", bus6.out_valid, dut6.r_pos_acc);
    end
    checks++;
    if (bus6.out_sum !== 7'd63 || bus6.out_act !== 2'b01) begin
      errors++; $display("FAIL narrow_out sum=%0d act=%b want 63/01", bus6.out_sum, bus6.out_act);
    end
    bus6.out_ready = 1'b1;
    @(posedge clk);
    #1 bus6.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   n;
    int   h;
    int   l;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      h = int'($urandom_range(0, 30)) - 15;
      l = h - int'($urandom_range(0, 20));
      if (i == 0) begin
        h = -3;
        l = 5;
      end
      drive({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
            8'(h), 8'(l));
      wait_out(n);
      e = sb.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || n != 9 || bus.out_sum !== e.sum || bus.out_act !== e.act) begin
        errors++;
        $display("FAIL b2b_%0d cycle=%0d sum=%0d act=%b want 9/%0d/%b", i, n, bus.out_sum, bus.out_act, e.sum, e.act);
      end
      release_out();
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %0b want 1", i, bus.in_ready); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    stuck  = 1'b0;
    rst    = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.in_x       = '0;
    bus.in_wpos    = '0;
    bus.in_wneg    = '0;
    bus.in_thr_hi  = '0;
    bus.in_thr_lo  = '0;
    bus6.in_valid  = 1'b0;
    bus6.out_ready = 1'b0;
    bus6.in_x      = '0;
    bus6.in_wpos   = '0;
    bus6.in_wneg   = '0;
    bus6.in_thr_hi = '0;
    bus6.in_thr_lo = '0;
    test_reset();
    test_all_pos();
    test_mixed();
    test_cancel();
    test_backpressure();
    test_mid_reset();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
